// File: rtl/wm_i2c_sequencer.sv
// WM8731 control sequencer: plays the codec power-up table through the shared
// I2C master, then forwards user register writes held in a one-entry buffer.
//
// Handshake with the I2C master: a command is offered by a one-cycle
// i2c_send_flag_o pulse, given only while i2c_busy_i is low; i2c_data_o stays
// stable from that pulse until i2c_done_i (sampled only in WAIT) or a timeout
// ends the command. On the user side, user_en_i is a one-cycle request that is
// either accepted (user_ack_o on the following cycle) or refused (user_drop_o).
module wm_i2c_sequencer #(
    parameter int GAP_CYCLES     = 500,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] user_data_i,
    input  logic        user_en_i,
    output logic        user_ack_o,
    output logic        user_drop_o,
    output logic [15:0] i2c_data_o,
    output logic        i2c_send_flag_o,
    input  logic        i2c_busy_i,
    input  logic        i2c_done_i,
    output logic        init_done_o,
    output logic        seq_busy_o,
    output logic        timeout_err_o,
    output logic [7:0]  cmd_count_o,
    output logic [2:0]  state_dbg_o
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [3:0] LAST_IDX = 4'd8;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [3:0]    idx, idx_n;
    logic [GW-1:0] gap_cnt, gap_n;
    logic [TW-1:0] to_cnt, to_n;
    logic [15:0]   data_n;
    logic [15:0]   buf_q;
    logic          buf_full;
    logic          drain;
    logic          flag_n;
    logic          err_set;
    logic          cnt_inc;
    logic          init_set;

    // Codec power-up words, sent in index order 0..8.
    function automatic logic [15:0] boot_word(input logic [3:0] i);
        case (i)
            4'd0:    boot_word = 16'h1E00;
            4'd1:    boot_word = 16'h0C00;
            4'd2:    boot_word = 16'h0812;
            4'd3:    boot_word = 16'h0A00;
            4'd4:    boot_word = 16'h0E02;
            4'd5:    boot_word = 16'h1000;
            4'd6:    boot_word = 16'h0479;
            4'd7:    boot_word = 16'h0679;
            4'd8:    boot_word = 16'h1201;
            default: boot_word = 16'h0000;
        endcase
    endfunction

    assign state_dbg_o = state;

    // Next-state and per-cycle control decisions for the command FSM.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        gap_n    = gap_cnt;
        to_n     = to_cnt;
        data_n   = i2c_data_o;
        drain    = 1'b0;
        flag_n   = 1'b0;
        err_set  = 1'b0;
        cnt_inc  = 1'b0;
        init_set = 1'b0;
        case (state)
            ST_BOOT: begin
                data_n  = boot_word(idx);
                state_n = ST_ISSUE;
            end
            ST_IDLE: begin
                if (buf_full) begin
                    data_n  = buf_q;
                    drain   = 1'b1;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!i2c_busy_i) begin
                    flag_n  = 1'b1;
                    to_n    = '0;
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done pulse on the terminal count cycle still counts as done.
                if (i2c_done_i) begin
                    cnt_inc = 1'b1;
                    gap_n   = '0;
                    state_n = ST_GAP;
                end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_set = 1'b1;
                    cnt_inc = 1'b1;
                    gap_n   = '0;
                    state_n = ST_GAP;
                end else begin
                    to_n = to_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    if (!init_done_o) begin
                        if (idx < LAST_IDX) begin
                            idx_n   = idx + 1'b1;
                            state_n = ST_BOOT;
                        end else begin
                            init_set = 1'b1;
                            state_n  = ST_IDLE;
                        end
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = ST_BOOT;
        endcase
    end

    // FSM state, counters and the command-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_BOOT;
            idx             <= '0;
            gap_cnt         <= '0;
            to_cnt          <= '0;
            i2c_data_o      <= 16'h0000;
            i2c_send_flag_o <= 1'b0;
            init_done_o     <= 1'b0;
            seq_busy_o      <= 1'b0;
            timeout_err_o   <= 1'b0;
            cmd_count_o     <= 8'd0;
        end else begin
            state           <= state_n;
            idx             <= idx_n;
            gap_cnt         <= gap_n;
            to_cnt          <= to_n;
            i2c_data_o      <= data_n;
            i2c_send_flag_o <= flag_n;
            seq_busy_o      <= (state_n != ST_IDLE);
            if (init_set) init_done_o <= 1'b1;
            if (err_set) timeout_err_o <= 1'b1;
            if (cnt_inc) cmd_count_o <= cmd_count_o + 8'd1;
        end
    end

    // Single-entry user buffer; a request arriving while it is full (including
    // the cycle IDLE drains it) is refused and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= 16'h0000;
            buf_full    <= 1'b0;
            user_ack_o  <= 1'b0;
            user_drop_o <= 1'b0;
        end else begin
            user_ack_o <= user_en_i && !buf_full;
            if (user_en_i) begin
                if (buf_full) begin
                    user_drop_o <= 1'b1;
                end else begin
                    buf_q    <= user_data_i;
                    buf_full <= 1'b1;
                end
            end
            if (drain) buf_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wm_i2c_sequencer.sv
// Directed bench for wm_i2c_sequencer: boot table, user buffer, drop, busy
// hold-off, reset mid-transfer and timeout, against a simple I2C master model.
module tb_wm_i2c_sequencer;

    localparam int GAP = 4;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] user_data_i = 16'h0000;
    logic        user_en_i = 1'b0;
    logic        user_ack_o;
    logic        user_drop_o;
    logic [15:0] i2c_data_o;
    logic        i2c_send_flag_o;
    logic        i2c_busy_i;
    logic        i2c_done_i;
    logic        init_done_o;
    logic        seq_busy_o;
    logic        timeout_err_o;
    logic [7:0]  cmd_count_o;
    logic [2:0]  state_dbg_o;

    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    logic f_busy = 1'b0;
    logic no_done = 1'b0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] exp_q[$];

    assign i2c_busy_i = m_busy | f_busy;
    assign i2c_done_i = m_done;

    wm_i2c_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .user_data_i(user_data_i), .user_en_i(user_en_i),
        .user_ack_o(user_ack_o), .user_drop_o(user_drop_o),
        .i2c_data_o(i2c_data_o), .i2c_send_flag_o(i2c_send_flag_o),
        .i2c_busy_i(i2c_busy_i), .i2c_done_i(i2c_done_i),
        .init_done_o(init_done_o), .seq_busy_o(seq_busy_o),
        .timeout_err_o(timeout_err_o), .cmd_count_o(cmd_count_o),
        .state_dbg_o(state_dbg_o)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // I2C master model: busy 20 cycles after each send pulse, then one done pulse
    initial begin
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (i2c_send_flag_o && !no_done) begin
                m_busy = 1'b1;
                repeat (20) @(negedge clk);
                m_busy = 1'b0;
                m_done = 1'b1;
                last_done_cyc = cyc;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_send(input string name, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i2c_send_flag_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: got no send pulse expected one within 3000 cycles", name);
        end
    endtask

    task automatic user_write(input logic [15:0] d);
        user_en_i   = 1'b1;
        user_data_i = d;
        @(negedge clk);
        user_en_i   = 1'b0;
    endtask

    typedef struct {
        logic        inject;
        logic [15:0] inj_data;
        logic [15:0] exp_word;
        logic [7:0]  exp_cnt;
        logic        exp_init;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic ok;
        logic [15:0] w;
        int pulses, run, max_run;
        logic [15:0] seen;

        vecs[0] = '{1'b0, 16'h0000, 16'h1E00, 8'd0, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 16'h0C00, 8'd1, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 16'h0812, 8'd2, 1'b0};
        vecs[3] = '{1'b1, 16'h0A08, 16'h0A00, 8'd3, 1'b0};
        vecs[4] = '{1'b0, 16'h0000, 16'h0E02, 8'd4, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 16'h1000, 8'd5, 1'b0};
        vecs[6] = '{1'b0, 16'h0000, 16'h0479, 8'd6, 1'b0};
        vecs[7] = '{1'b0, 16'h0000, 16'h0679, 8'd7, 1'b0};
        vecs[8] = '{1'b0, 16'h0000, 16'h1201, 8'd8, 1'b0};
        vecs[9] = '{1'b0, 16'h0000, 16'h0A08, 8'd9, 1'b1};

        // reset values
        repeat (3) @(negedge clk);
        check("rst_ack", {15'd0, user_ack_o}, 16'd0);
        check("rst_drop", {15'd0, user_drop_o}, 16'd0);
        check("rst_data", i2c_data_o, 16'h0000);
        check("rst_flag", {15'd0, i2c_send_flag_o}, 16'd0);
        check("rst_init", {15'd0, init_done_o}, 16'd0);
        check("rst_busy", {15'd0, seq_busy_o}, 16'd0);
        check("rst_err", {15'd0, timeout_err_o}, 16'd0);
        check("rst_count", {8'd0, cmd_count_o}, 16'd0);
        rst_n = 1'b1;

        // boot sequence plus a user word captured during boot word 3
        foreach (vecs[k]) exp_q.push_back(vecs[k].exp_word);
        for (int k = 0; k < 10; k++) begin
            wait_send($sformatf("send%0d", k), ok);
            if (ok) begin
                w = exp_q.pop_front();
                check($sformatf("word%0d", k), i2c_data_o, w);
                check($sformatf("count%0d", k), {8'd0, cmd_count_o}, {8'd0, vecs[k].exp_cnt});
                check($sformatf("init%0d", k), {15'd0, init_done_o}, {15'd0, vecs[k].exp_init});
                if (k == 0) check("busy_boot", {15'd0, seq_busy_o}, 16'd1);
                if (k > 0) check($sformatf("gap%0d", k), {15'd0, (cyc - last_done_cyc) > GAP}, 16'd1);
                if (vecs[k].inject) begin
                    user_write(vecs[k].inj_data);
                    check("boot_ack", {15'd0, user_ack_o}, 16'd1);
                end
            end
        end
        repeat (40) @(negedge clk);
        check("idle_busy", {15'd0, seq_busy_o}, 16'd0);
        check("idle_count", {8'd0, cmd_count_o}, 16'd10);
        check("no_drop_yet", {15'd0, user_drop_o}, 16'd0);

        // two requests one cycle apart: second collides with the drain
        user_en_i = 1'b1;
        user_data_i = 16'h0811;
        @(negedge clk);
        check("t3_ack_a", {15'd0, user_ack_o}, 16'd1);
        user_data_i = 16'h0C10;
        @(negedge clk);
        user_en_i = 1'b0;
        check("t3_ack_b", {15'd0, user_ack_o}, 16'd0);
        check("t3_drop", {15'd0, user_drop_o}, 16'd1);
        check("t3_flag_early", {15'd0, i2c_send_flag_o}, 16'd0);
        @(negedge clk);
        check("t3_flag_latency", {15'd0, i2c_send_flag_o}, 16'd1);
        check("t3_word", i2c_data_o, 16'h0811);
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i2c_send_flag_o) pulses++;
        end
        check("t3_extra_sends", 16'(pulses), 16'd0);
        check("t3_count", {8'd0, cmd_count_o}, 16'd11);

        // master held busy: no send until it drops, then a single pulse
        f_busy = 1'b1;
        user_write(16'h0E42);
        check("t5_ack", {15'd0, user_ack_o}, 16'd1);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i2c_send_flag_o) pulses++;
        end
        check("t5_held", 16'(pulses), 16'd0);
        check("t5_state", {13'd0, state_dbg_o}, 16'd2);
        f_busy = 1'b0;
        pulses = 0;
        run = 0;
        max_run = 0;
        seen = 16'h0000;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i2c_send_flag_o) begin
                if (run == 0) pulses++;
                run++;
                seen = i2c_data_o;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        check("t5_pulses", 16'(pulses), 16'd1);
        check("t5_width", 16'(max_run), 16'd1);
        check("t5_word", seen, 16'h0E42);

        // restart boot, then reset in WAIT of boot word 5
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_send($sformatf("reboot%0d", k), ok);
            if (ok) check($sformatf("reboot_word%0d", k), i2c_data_o, vecs[k].exp_word);
        end
        check("t6_count_pre", {8'd0, cmd_count_o}, 16'd5);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_data", i2c_data_o, 16'h0000);
        check("t6_count", {8'd0, cmd_count_o}, 16'd0);
        check("t6_flag", {15'd0, i2c_send_flag_o}, 16'd0);
        check("t6_busy", {15'd0, seq_busy_o}, 16'd0);
        check("t6_drop", {15'd0, user_drop_o}, 16'd0);
        no_done = 1'b1;
        repeat (30) @(negedge clk);
        rst_n = 1'b1;

        // first word after release times out
        wait_send("t6_first", ok);
        if (ok) begin
            check("t6_first_word", i2c_data_o, 16'h1E00);
            check("t6_init", {15'd0, init_done_o}, 16'd0);
            repeat (99) @(negedge clk);
            check("t4_err_early", {15'd0, timeout_err_o}, 16'd0);
            @(negedge clk);
            check("t4_err", {15'd0, timeout_err_o}, 16'd1);
            check("t4_count", {8'd0, cmd_count_o}, 16'd1);
        end
        no_done = 1'b0;
        wait_send("t4_next", ok);
        if (ok) begin
            check("t4_next_word", i2c_data_o, 16'h0C00);
            check("t4_err_sticky", {15'd0, timeout_err_o}, 16'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
